// File: rtl/sar_search.sv
// sar_search: successive-approximation search controller.
// Drives the B side of an external combinational magnitude comparator with a
// registered trial value and uses the gt/lt/eq answers to find the target
// held on the A side. One decision per clock. The search is MSB first, with
// one extra CHECK compare after bit 0 has been decided.
module sar_search #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  input  logic         cmp_eq,
  output logic [N-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] result,
  output logic [7:0]   steps
);

  localparam int unsigned KW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] k;

  logic [N-1:0] bit_k;
  logic [N-1:0] bit_km1;
  logic [N-1:0] trial_dec;
  logic         k_zero;

  // cmp_lt is not used directly. Any answer other than eq or gt clears the bit,
  // so "no flag asserted" behaves the same as lt.
  logic unused_lt;
  assign unused_lt = cmp_lt;

  // Per-cycle bit decision: one-hot of bit k, the next bit to try, and the
  // trial value with bit k settled.
  always_comb begin
    bit_k        = '0;
    bit_k[k]     = 1'b1;
    bit_km1      = bit_k >> 1;
    k_zero       = (k == '0);
    trial_dec    = cmp_gt ? trial : (trial & ~bit_k);
  end

  // Search state machine and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      trial  <= '0;
      result <= '0;
      steps  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trial  <= {1'b1, {(N-1){1'b0}}};
            k      <= KW'(N-1);
            busy   <= 1'b1;
            found  <= 1'b0;
            result <= '0;
            steps  <= '0;
            state  <= SEARCH;
          end
        end

        SEARCH: begin
          steps <= steps + 8'd1;
          if (cmp_eq) begin
            result <= trial;
            found  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            // bit_km1 is zero when k==0, so only the bit-0 decision is applied
            // before moving on to CHECK.
            trial <= trial_dec | bit_km1;
            if (k_zero) begin
              state <= CHECK;
            end else begin
              k <= k - KW'(1);
            end
          end
        end

        CHECK: begin
          steps  <= steps + 8'd1;
          result <= trial;
          found  <= cmp_eq;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (N=16) with a behavioural comparator that
// can be forced into stuck-gt or all-flags-zero fault modes.
module tb_sar_search;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cmp_gt;
  logic        cmp_lt;
  logic        cmp_eq;
  logic [15:0] trial;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] result;
  logic [7:0]  steps;

  logic [15:0] target;
  int          mode;   // 0 real comparator, 1 gt stuck, 2 all flags 0
  int          total;
  int          bad;

  sar_search #(.N(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator model
  always_comb begin
    cmp_gt = 1'b0;
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    if (mode == 0) begin
      cmp_gt = (target > trial);
      cmp_lt = (target < trial);
      cmp_eq = (target == trial);
    end else if (mode == 1) begin
      cmp_gt = 1'b1;
    end
  end

  // Pulse start, then wait (bounded) for done. Cycles are counted from the
  // accepting edge, so cycles equals the number of compare edges.
  task automatic do_search(input logic [15:0] tgt, output int cycles,
                           output logic [15:0] first_trial, output logic to);
    @(negedge clk);
    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_trial = trial;
    cycles = 0;
    to = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({trial, result, steps, busy, done, found} !== 43'd0) begin
      bad++;
      $display("FAIL reset: trial=%h result=%h steps=%0d busy=%b done=%b found=%b, want all 0",
               trial, result, steps, busy, done, found);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_msb_target();
    int cyc; logic [15:0] ft; logic to;
    do_search(16'h8000, cyc, ft, to);
    total++;
    if (to) begin bad++; $display("FAIL msb_timeout: done never seen, want done"); end
    total++;
    if (ft !== 16'h8000) begin bad++; $display("FAIL msb_first_trial: got %h want 8000", ft); end
    total++;
    if ({result, found, steps, busy} !== {16'h8000, 1'b1, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL msb_result: result=%h found=%b steps=%0d busy=%b want 8000 1 1 0",
               result, found, steps, busy);
    end
    total++;
    if (cyc != 1) begin bad++; $display("FAIL msb_latency: got %0d want 1", cyc); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL msb_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_zero_target();
    int cyc; logic [15:0] ft; logic to;
    do_search(16'h0000, cyc, ft, to);
    total++;
    if (to || {result, found, steps, trial} !== {16'h0000, 1'b1, 8'd17, 16'h0000}) begin
      bad++;
      $display("FAIL zero_target: to=%b result=%h found=%b steps=%0d trial=%h want 0 0000 1 17 0000",
               to, result, found, steps, trial);
    end
  endtask

  task automatic test_full_and_mid();
    int cyc; logic [15:0] ft; logic to;
    logic [15:0] exp_trial;
    int n;
    do_search(16'hFFFF, cyc, ft, to);
    total++;
    if (to || {result, found, steps, trial} !== {16'hFFFF, 1'b1, 8'd16, 16'hFFFF}) begin
      bad++;
      $display("FAIL full_target: to=%b result=%h found=%b steps=%0d trial=%h want 0 ffff 1 16 ffff",
               to, result, found, steps, trial);
    end
    // 0x1234: check every trial against a binary-search golden sequence.
    // Lowest set bit is bit 2, so eq occurs at k=2 -> 14 compares.
    @(negedge clk);
    target = 16'h1234;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_trial = 16'h8000;
    n = 0;
    for (int b = 15; b >= 0; b--) begin
      total++;
      if (trial !== exp_trial) begin
        bad++;
        $display("FAIL mid_trial_k%0d: got %h want %h", b, trial, exp_trial);
      end
      if (exp_trial == target) break;
      if (!(target > exp_trial)) exp_trial[b] = 1'b0;
      if (b > 0) exp_trial[b-1] = 1'b1;
      @(negedge clk);
      n++;
    end
    while (!done && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({done, result, found, steps} !== {1'b1, 16'h1234, 1'b1, 8'd14}) begin
      bad++;
      $display("FAIL mid_result: done=%b result=%h found=%b steps=%0d want 1 1234 1 14",
               done, result, found, steps);
    end
  endtask

  task automatic test_stuck_comparator();
    int cyc; logic [15:0] ft; logic to;
    mode = 1;
    do_search(16'h0000, cyc, ft, to);
    total++;
    if (to || {result, found, steps} !== {16'hFFFF, 1'b0, 8'd17}) begin
      bad++;
      $display("FAIL stuck_gt: to=%b result=%h found=%b steps=%0d want 0 ffff 0 17",
               to, result, found, steps);
    end
    mode = 2;
    do_search(16'h0000, cyc, ft, to);
    total++;
    if (to || {result, found, steps} !== {16'h0000, 1'b0, 8'd17}) begin
      bad++;
      $display("FAIL no_flags: to=%b result=%h found=%b steps=%0d want 0 0000 0 17",
               to, result, found, steps);
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    target = 16'h0000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      start = (n == 3 || n == 5);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    total++;
    if ({done, result, found, steps} !== {1'b1, 16'h0000, 1'b1, 8'd17}) begin
      bad++;
      $display("FAIL ignore_start: done=%b result=%h found=%b steps=%0d want 1 0000 1 17",
               done, result, found, steps);
    end
    // Restart during the done cycle
    target = 16'h00FF;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, found, result, steps, trial} !== {1'b1, 1'b0, 16'h0000, 8'd0, 16'h8000}) begin
      bad++;
      $display("FAIL restart_clear: busy=%b found=%b result=%h steps=%0d trial=%h want 1 0 0000 0 8000",
               busy, found, result, steps, trial);
    end
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    total++;
    if ({done, result, found, steps} !== {1'b1, 16'h00FF, 1'b1, 8'd16}) begin
      bad++;
      $display("FAIL restart_result: done=%b result=%h found=%b steps=%0d want 1 00ff 1 16",
               done, result, found, steps);
    end
  endtask

  task automatic test_async_reset();
    int cyc; logic [15:0] ft; logic to;
    @(negedge clk);
    target = 16'h1234;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({trial, result, steps, busy, done, found} !== 43'd0) begin
      bad++;
      $display("FAIL async_reset: trial=%h result=%h steps=%0d busy=%b done=%b found=%b, want all 0",
               trial, result, steps, busy, done, found);
    end
    @(negedge clk);
    rst = 1'b0;
    // 0x0AB0: lowest set bit is bit 4 -> 12 compares
    do_search(16'h0AB0, cyc, ft, to);
    total++;
    if (to || {result, found, steps} !== {16'h0AB0, 1'b1, 8'd12}) begin
      bad++;
      $display("FAIL post_reset: to=%b result=%h found=%b steps=%0d want 0 0ab0 1 12",
               to, result, found, steps);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mode   = 0;
    target = 16'h0000;
    start  = 1'b0;
    rst    = 1'b0;
    test_reset();
    test_msb_target();
    test_zero_target();
    test_full_and_mid();
    test_stuck_comparator();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
